robert_2x2_window: RTL
======================

Name: robert_2x2_window

Overview:
- Upstream neighbour of the Roberts sharpen stage. Turns a raster gray pixel stream into a 2x2 neighbourhood per input pixel, using one line buffer.
- Outputs the 2x2 window plus edge flags and delayed syncs, so a Roberts operator can consume it without a 3x3 generator.
- Window is causal: it ends at the current pixel. p22 = (r,c), p21 = (r,c-1), p12 = (r-1,c), p11 = (r-1,c-1).

Parameters:
- IMG_H_DISP, 640, active pixels per line; sets line buffer depth and column wrap.
- IMG_V_DISP, 480, active lines per frame; sets row wrap and bottom flag.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pre_img_vsync  in  1  frame sync, active high; rising edge marks frame start
- pre_img_hsync  in  1  line sync, delay-matched only
- pre_img_valid  in  1  pixel qualifier
- pre_img_data  in  DATA_W  gray pixel
- matrix_img_vsync  out  1  pre_img_vsync delayed 2 clk
- matrix_img_hsync  out  1  pre_img_hsync delayed 2 clk
- matrix_img_valid  out  1  pre_img_valid delayed 2 clk
- matrix_top_edge_flag  out  1  window pixel row = 0
- matrix_bottom_edge_flag  out  1  row = IMG_V_DISP-1
- matrix_left_edge_flag  out  1  col = 0
- matrix_right_edge_flag  out  1  col = IMG_H_DISP-1
- matrix_p11, matrix_p12, matrix_p21, matrix_p22  out  DATA_W each  window pixels

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: all outputs 0; col and row counters 0; delay registers 0. Line-buffer RAM contents are not reset.
- Latency: exactly 2 clk from pre_img_valid/hsync/vsync/data to the matrix_* outputs, fixed, no backpressure.
- Frame start: vsync_r registers pre_img_vsync. A rising edge (pre_img_vsync & ~vsync_r) forces col = 0, row = 0.
  - If pre_img_valid is high in that same cycle, that pixel is (0,0) and the counters advance from there.
- Counters: col increments on each valid pixel.
  - At IMG_H_DISP-1 a valid pixel wraps col to 0 and increments row.
  - row wraps IMG_V_DISP-1 -> 0.
  - Counting is valid-based; hsync is never used for counting.
- Line buffer: IMG_H_DISP x DATA_W, single clock, read-before-write.
  - On a valid pixel, read address = col and write address = col with pre_img_data.
  - The read returns (r-1,c) one cycle later.
- Stage 1 (registered): cur_pix, col/row tags of the pixel, valid and syncs.
- Stage 2 (registered, updates only when stage-1 valid): prev_cur and prev_up hold stage-1 cur/up from the previous valid pixel.
  - Outputs: p22 = cur, p12 = up, p21 = prev_cur, p11 = prev_up.
- Edge replication:
  - row = 0: up := cur, so p12 = p22 and p11 = p21.
  - col = 0: p21 := p22 and p11 := p12.
  - Both apply at (0,0): all four = p22.
- Flags: computed from stage-1 tags and registered with the window. Forced 0 when matrix_img_valid = 0.
- Blanking: when invalid, p11..p22 hold their last values; the line buffer is not written and counters do not move.
- Overlong line (more than IMG_H_DISP valid pixels): wrap to the next row per counter rule, no error.
- Short frame: the next vsync rising edge resynchronises.
- Reset mid-frame: the next valid pixel is treated as (0,0); output is 0 until 2 clk after the first post-reset valid.

Test Plan:
- Setup for all scenarios: IMG_H_DISP=4, IMG_V_DISP=3, pixel(r,c) = 16r+c, valid continuous in lines with 2 idle clk between lines.
- Frame start: vsync pulse, then pixel (0,0) = 0 -> 2 clk later valid=1, p11=p12=p21=p22=0, top=left=1, right=bottom=0.
- Interior: pixel (1,2) = 18 -> p11=1, p12=2, p21=17, p22=18, all flags 0.
- Column replication: pixel (1,0) = 16 -> p11=p12=0, p21=p22=16, left=1. Pixel (0,3) = 3 -> p11=p21=2, p12=p22=3, top=right=1.
- Bottom-right and wrap: pixel (2,3) = 35 -> p11=18, p12=19, p21=34, p22=35, bottom=right=1. A 13th pixel without vsync is treated as (0,0) with top=left=1.
- Resync and reset:
  - Vsync rising edge coincident with a valid pixel after 1.5 lines -> that pixel reports (0,0) flags.
  - rst_n low for 1 clk mid-line -> all outputs 0 the next clk; the first post-reset pixel gets top=left=1 after 2 clk.
  - matrix_img_hsync/vsync stay exactly 2 clk behind their inputs throughout.

Source files
------------

// File: rtl/robert_2x2_window.sv
// 2x2 causal neighbourhood generator for the Roberts stage.
// One line buffer supplies the pixel above; a two-stage pipeline builds the
// window, replicates edges and carries the syncs with a fixed 2-clock latency.
module robert_2x2_window #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    output logic              matrix_img_vsync,
    output logic              matrix_img_hsync,
    output logic              matrix_img_valid,
    output logic              matrix_top_edge_flag,
    output logic              matrix_bottom_edge_flag,
    output logic              matrix_left_edge_flag,
    output logic              matrix_right_edge_flag,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22
);

    localparam int COL_W = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
    localparam int ROW_W = (IMG_V_DISP > 1) ? $clog2(IMG_V_DISP) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_H_DISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_V_DISP - 1);

    logic              vsync_r;
    logic              frame_start;
    logic [COL_W-1:0]  col, eff_col;
    logic [ROW_W-1:0]  row, eff_row;

    logic [DATA_W-1:0] line_buf [IMG_H_DISP];
    logic [DATA_W-1:0] lb_rd;

    logic              s1_valid, s1_hsync, s1_vsync;
    logic [DATA_W-1:0] s1_cur, s1_up;
    logic [COL_W-1:0]  s1_col;
    logic [ROW_W-1:0]  s1_row;

    // A vsync rising edge makes the current cycle's position (0,0).
    always_comb begin
        frame_start = pre_img_vsync & ~vsync_r;
        eff_col     = frame_start ? '0 : col;
        eff_row     = frame_start ? '0 : row;
    end

    // Column/row counters advance on valid pixels only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            vsync_r <= pre_img_vsync;
            if (pre_img_valid) begin
                if (eff_col == COL_LAST) begin
                    col <= '0;
                    row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
                end else begin
                    col <= eff_col + COL_W'(1);
                    row <= eff_row;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Line buffer, read-before-write: lb_rd returns the pixel one row up.
    always_ff @(posedge clk) begin
        if (pre_img_valid) begin
            lb_rd             <= line_buf[eff_col];
            line_buf[eff_col] <= pre_img_data;
        end
    end

    // Stage 1: current pixel with its position tags and delayed syncs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_cur   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= pre_img_valid;
            s1_hsync <= pre_img_hsync;
            s1_vsync <= pre_img_vsync;
            if (pre_img_valid) begin
                s1_cur <= pre_img_data;
                s1_col <= eff_col;
                s1_row <= eff_row;
            end
        end
    end

    // Top row has no line above: replicate the current pixel upward.
    always_comb begin
        s1_up = (s1_row == '0) ? s1_cur : lb_rd;
    end

    // Stage 2: window assembly; previous p22/p12 serve as the left column.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            matrix_img_valid        <= 1'b0;
            matrix_img_hsync        <= 1'b0;
            matrix_img_vsync        <= 1'b0;
            matrix_top_edge_flag    <= 1'b0;
            matrix_bottom_edge_flag <= 1'b0;
            matrix_left_edge_flag   <= 1'b0;
            matrix_right_edge_flag  <= 1'b0;
            matrix_p11              <= '0;
            matrix_p12              <= '0;
            matrix_p21              <= '0;
            matrix_p22              <= '0;
        end else begin
            matrix_img_valid        <= s1_valid;
            matrix_img_hsync        <= s1_hsync;
            matrix_img_vsync        <= s1_vsync;
            matrix_top_edge_flag    <= s1_valid & (s1_row == '0);
            matrix_bottom_edge_flag <= s1_valid & (s1_row == ROW_LAST);
            matrix_left_edge_flag   <= s1_valid & (s1_col == '0);
            matrix_right_edge_flag  <= s1_valid & (s1_col == COL_LAST);
            if (s1_valid) begin
                matrix_p22 <= s1_cur;
                matrix_p12 <= s1_up;
                matrix_p21 <= (s1_col == '0) ? s1_cur : matrix_p22;
                matrix_p11 <= (s1_col == '0) ? s1_up : matrix_p12;
            end
        end
    end

endmodule
